// File: rtl/rob_tag_allocator_if.sv
// rtl/rob_tag_allocator_if.sv - dispatch-side bundle between producer and ROB tag allocator
interface rob_tag_allocator_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_dado;
    logic [ADDR_W-1:0] in_endereco;
    logic              retire;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_dado;
    logic [ADDR_W-1:0] out_endereco;
    logic [TAG_W-1:0]  out_contador;
    logic [TAG_W:0]    occupancy;
    logic              err_underflow;

    // Producer / ROB side: drives entries, retire and flush, observes tags.
    modport master (
        output in_valid, in_dado, in_endereco, retire, flush,
        input  in_ready, out_valid, out_dado, out_endereco, out_contador,
               occupancy, err_underflow
    );

    // Allocator side.
    modport slave (
        input  in_valid, in_dado, in_endereco, retire, flush,
        output in_ready, out_valid, out_dado, out_endereco, out_contador,
               occupancy, err_underflow
    );
endinterface

// File: rtl/rob_tag_allocator.sv
// rtl/rob_tag_allocator.sv - in-order ROB slot allocator with occupancy tracking and flush
module rob_tag_allocator #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 5
) (
    input logic                clk,
    input logic                rst,
    rob_tag_allocator_if.slave bus
);
    localparam int DEPTH = 2 ** TAG_W;
    localparam logic [TAG_W:0] FULL = (TAG_W + 1)'(DEPTH);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   occ;
    logic             alloc;
    logic             do_retire;
    logic             underflow_hit;

    // Retire only counts in RUN and loses to a same-cycle flush.
    assign do_retire     = (state == S_RUN) && !bus.flush && bus.retire && (occ != '0);
    assign underflow_hit = (state == S_RUN) && !bus.flush && bus.retire && (occ == '0);
    // Writes to x0 complete the handshake but never take a slot.
    assign alloc         = bus.in_valid && bus.in_ready && (bus.in_endereco != ADDR_W'(0));
    assign bus.occupancy = occ;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_RUN;
        else      state <= state_nxt;
    end

    // Next state: flush enters FLUSH, which always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (bus.flush) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    // Ready is purely from registered state and flush so a same-cycle retire cannot raise it.
    always_comb begin
        bus.in_ready = 1'b0;
        if (rst && (state == S_RUN) && (occ < FULL) && !bus.flush)
            bus.in_ready = 1'b1;
    end

    // Tag pointers, occupancy and the registered output entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head             <= '0;
            tail             <= '0;
            occ              <= '0;
            bus.out_valid    <= 1'b0;
            bus.out_dado     <= DATA_W'(0);
            bus.out_endereco <= ADDR_W'(0);
            bus.out_contador <= '0;
        end else if (bus.flush) begin
            tail          <= head;
            occ           <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= alloc;
            if (alloc) begin
                bus.out_dado     <= bus.in_dado;
                bus.out_endereco <= bus.in_endereco;
                bus.out_contador <= tail;
                tail             <= tail + 1'b1;
            end
            if (do_retire)
                head <= head + 1'b1;
            case ({alloc, do_retire})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst)               bus.err_underflow <= 1'b0;
        else if (underflow_hit) bus.err_underflow <= 1'b1;
    end
endmodule

// File: tb/tb_rob_tag_allocator.sv
// tb/tb_rob_tag_allocator.sv - randomized bench for rob_tag_allocator against a queue model
module tb_rob_tag_allocator;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rob_tag_allocator_if #(.DATA_W(32), .ADDR_W(5), .TAG_W(5)) bus ();

    rob_tag_allocator #(.DATA_W(32), .ADDR_W(5), .TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: list of tags live in the ROB, oldest first, plus the next tag to hand out.
    int          q[$];
    int          next_tag;
    bit          m_flushing;
    bit          m_err;
    bit          m_ov;
    int          m_tag;
    logic [31:0] m_dado;
    logic [4:0]  m_end;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_tag   = 0;
        m_flushing = 1'b0;
        m_err      = 1'b0;
        m_ov       = 1'b0;
        m_tag      = 0;
        m_dado     = '0;
        m_end      = '0;
    endtask

    task automatic check_outputs();
        check("out_valid", bus.out_valid, m_ov);
        check("occupancy", bus.occupancy, q.size());
        check("err_underflow", bus.err_underflow, m_err);
        check("out_contador", bus.out_contador, m_tag);
        check("out_dado", bus.out_dado, m_dado);
        check("out_endereco", bus.out_endereco, m_end);
    endtask

    task automatic do_reset(input bit v);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = v; bus.in_dado = 32'hA5A5_0001; bus.in_endereco = 5'd3;
        bus.retire = 1'b0; bus.flush = 1'b0;
        #1;
        check("in_ready_in_reset", bus.in_ready, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic step(input bit v, input logic [31:0] d, input logic [4:0] e,
                        input bit r, input bit f);
        bit exp_ready;
        bit acc;
        int sz0;
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = v; bus.in_dado = d; bus.in_endereco = e;
        bus.retire = r; bus.flush = f;
        #1;
        exp_ready = !m_flushing && (q.size() < DEPTH) && !f;
        check("in_ready", bus.in_ready, exp_ready);
        acc = v && exp_ready;
        if (f) begin
            if (q.size() > 0) next_tag = q[0];
            q.delete();
            m_ov       = 1'b0;
            m_flushing = 1'b1;
        end else begin
            sz0 = q.size();
            if (acc && e != 5'd0) begin
                q.push_back(next_tag);
                m_ov     = 1'b1;
                m_tag    = next_tag;
                m_dado   = d;
                m_end    = e;
                next_tag = (next_tag + 1) % DEPTH;
            end else begin
                m_ov = 1'b0;
            end
            if (r && !m_flushing) begin
                if (sz0 > 0) void'(q.pop_front());
                else         m_err = 1'b1;
            end
            m_flushing = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic random_run(input int n);
        bit last_f = 1'b0;
        bit f;
        for (int i = 0; i < n; i++) begin
            f = !last_f && ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 3) != 0, $urandom(),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 $urandom_range(0, 2) == 0, f);
            last_f = f;
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_dado = '0; bus.in_endereco = '0;
        bus.retire = 1'b0; bus.flush = 1'b0;
        model_reset();

        do_reset(1'b1);
        do_reset(1'b1);
        idle();

        // First tags 0 and 1.
        step(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b0);
        check("first_tag", bus.out_contador, 5'd0);
        check("first_end", bus.out_endereco, 5'd3);
        step(1'b1, 32'h1234_5678, 5'd7, 1'b0, 1'b0);
        check("second_tag", bus.out_contador, 5'd1);

        // Fill to full, try to overfill, retire one, wrap tag to 0.
        for (int i = 0; i < 30; i++) step(1'b1, $urandom(), 5'd9, 1'b0, 1'b0);
        check("full_occ", bus.occupancy, 6'd32);
        step(1'b1, 32'h0BAD_0BAD, 5'd4, 1'b0, 1'b0);
        step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        step(1'b1, 32'hCAFE_F00D, 5'd5, 1'b0, 1'b0);
        check("wrap_tag", bus.out_contador, 5'd0);

        // Drain, then x0 write is consumed without a tag.
        for (int i = 0; i < 32; i++) step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        step(1'b1, 32'h1111_2222, 5'd0, 1'b0, 1'b0);

        // Occupancy 5 with accept+retire, then underflow.
        for (int i = 0; i < 5; i++) step(1'b1, $urandom(), 5'd6, 1'b0, 1'b0);
        step(1'b1, 32'h5555_AAAA, 5'd4, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        check("underflow_set", bus.err_underflow, 1'b1);
        idle();
        idle();

        // Occupancy 7, flush with valid and retire, then next tag is old head.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom(), 5'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, $urandom(), 5'd2, 1'b0, 1'b0);
        step(1'b1, 32'h7777_7777, 5'd2, 1'b1, 1'b1);
        step(1'b1, 32'h8888_8888, 5'd2, 1'b0, 1'b0);
        step(1'b1, 32'h9999_9999, 5'd2, 1'b0, 1'b0);
        check("tag_after_flush", bus.out_contador, 5'd3);

        random_run(1500);
        do_reset(1'b1);
        random_run(1500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
